// File: rtl/enc_pkg.sv
// Shared types and constants for the PmodENC step controller: FSM state
// encoding, hex glyph table and the pure next-state/counter helpers.
package enc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CW1  = 3'd1,
      ST_CW2  = 3'd2,
      ST_CW3  = 3'd3,
      ST_CCW1 = 3'd4,
      ST_CCW2 = 3'd5,
      ST_CCW3 = 3'd6,
      ST_ERR  = 3'd7
   } enc_state_e;

   localparam logic [6:0] SEG_RESET = 7'h3F;

   // Active-high a..g glyphs, seg[0]=a ... seg[6]=g
   localparam logic [6:0] HEX_SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic enc_state_e enc_next_state(input enc_state_e st, input logic [1:0] ab);
      enc_state_e nxt;
      nxt = st;
      case (st)
         ST_IDLE: begin
            case (ab)
               2'b01:   nxt = ST_CW1;
               2'b10:   nxt = ST_CCW1;
               2'b11:   nxt = ST_ERR;
               default: nxt = st;
            endcase
         end
         ST_CW1: begin
            case (ab)
               2'b11:   nxt = ST_CW2;
               2'b00:   nxt = ST_IDLE;
               2'b10:   nxt = ST_ERR;
               default: nxt = st;
            endcase
         end
         ST_CW2: begin
            case (ab)
               2'b10:   nxt = ST_CW3;
               2'b01:   nxt = ST_CW1;
               2'b00:   nxt = ST_ERR;
               default: nxt = st;
            endcase
         end
         ST_CW3: begin
            case (ab)
               2'b00:   nxt = ST_IDLE;
               2'b11:   nxt = ST_CW2;
               2'b01:   nxt = ST_ERR;
               default: nxt = st;
            endcase
         end
         ST_CCW1: begin
            case (ab)
               2'b11:   nxt = ST_CCW2;
               2'b00:   nxt = ST_IDLE;
               2'b01:   nxt = ST_ERR;
               default: nxt = st;
            endcase
         end
         ST_CCW2: begin
            case (ab)
               2'b01:   nxt = ST_CCW3;
               2'b10:   nxt = ST_CCW1;
               2'b00:   nxt = ST_ERR;
               default: nxt = st;
            endcase
         end
         ST_CCW3: begin
            case (ab)
               2'b00:   nxt = ST_IDLE;
               2'b11:   nxt = ST_CCW2;
               2'b10:   nxt = ST_ERR;
               default: nxt = st;
            endcase
         end
         ST_ERR: begin
            if (ab == 2'b00) nxt = ST_IDLE;
         end
         default: nxt = ST_IDLE;
      endcase
      return nxt;
   endfunction

   // >= rather than == keeps the counter in range even if max shrinks later
   function automatic logic [3:0] enc_step_count(input logic [3:0] cnt, input logic up,
                                                 input logic sat, input logic [3:0] max);
      logic [3:0] res;
      res = cnt;
      if (up) begin
         if (cnt >= max) res = sat ? max : 4'd0;
         else            res = cnt + 4'd1;
      end else begin
         if (cnt == 4'd0) res = sat ? 4'd0 : max;
         else             res = cnt - 4'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/enc_debounce.sv
// Two-flop synchronizer followed by a stable-count filter: the output follows
// the synchronized input only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
module enc_debounce #(
   parameter int DEBOUNCE_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic din_raw,
   output logic dout
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic          sync1_q, sync2_q;
   logic          filt_q, filt_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d  = '0;
      filt_d = filt_q;
      if (sync2_q != filt_q) begin
         if (cnt_q == CNT_LAST) filt_d = sync2_q;
         else                   cnt_d  = cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         filt_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= din_raw;
         sync2_q <= sync1_q;
         filt_q  <= filt_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dout = filt_q;

endmodule

// File: rtl/enc_step_ctrl.sv
// PmodENC step controller: debounced quadrature FSM, 4-bit step counter,
// button clear and hex display. Optional macro ENC_ERR_LED_EN routes a sticky
// quadrature-error flag to led instead of dir.
//
// state   | meaning
// IDLE    | detent position, A=B=0
// CW1..3  | partway through a clockwise detent (01, 11, 10)
// CCW1..3 | partway through a counter-clockwise detent (10, 11, 01)
// ERR     | illegal jump seen, waiting for 00 before accepting detents again
module enc_step_ctrl
   import enc_pkg::*;
#(
   parameter int         DEBOUNCE_CYCLES = 1024,
   parameter logic [3:0] COUNT_MAX       = 4'd15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enc_a,
   input  logic       enc_b,
   input  logic       enc_btn,
   input  logic       enc_sw,
   output logic [3:0] count,
   output logic       step_pulse,
   output logic       dir,
   output logic [6:0] seg,
   output logic       led
);

   logic a_f, b_f, btn_f, sw_f;

   enc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
      .clk(clk), .rst(rst), .din_raw(enc_a), .dout(a_f)
   );
   enc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
      .clk(clk), .rst(rst), .din_raw(enc_b), .dout(b_f)
   );
   enc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_btn (
      .clk(clk), .rst(rst), .din_raw(enc_btn), .dout(btn_f)
   );
   enc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sw (
      .clk(clk), .rst(rst), .din_raw(enc_sw), .dout(sw_f)
   );

   enc_state_e state_q, state_d;
   logic [3:0] count_q;
   logic       step_pulse_q;
   logic       dir_q;
   logic [6:0] seg_q;
   logic       btn_prev_q;
   logic       clear_d;
   logic       step_cw_d, step_ccw_d, step_d;

   assign state_d    = enc_next_state(state_q, {a_f, b_f});
   assign clear_d    = btn_f & ~btn_prev_q;
   assign step_cw_d  = (state_q == ST_CW3)  && (state_d == ST_IDLE);
   assign step_ccw_d = (state_q == ST_CCW3) && (state_d == ST_IDLE);
   assign step_d     = step_cw_d | step_ccw_d;

   // Clear overrides the count update but not the strobe or direction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         count_q      <= 4'd0;
         step_pulse_q <= 1'b0;
         dir_q        <= 1'b0;
         seg_q        <= SEG_RESET;
         btn_prev_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         btn_prev_q   <= btn_f;
         step_pulse_q <= step_d;
         seg_q        <= HEX_SEG[count_q];
         if (step_d) dir_q <= step_cw_d;
         if (clear_d)     count_q <= 4'd0;
         else if (step_d) count_q <= enc_step_count(count_q, step_cw_d, sw_f, COUNT_MAX);
      end
   end

`ifdef ENC_ERR_LED_EN
   logic err_flag_q;

   // A fresh error entry outranks a simultaneous clear so it is never lost
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_flag_q <= 1'b0;
      end else if ((state_d == ST_ERR) && (state_q != ST_ERR)) begin
         err_flag_q <= 1'b1;
      end else if (clear_d) begin
         err_flag_q <= 1'b0;
      end
   end

   assign led = err_flag_q;
`else
   assign led = dir_q;
`endif

   assign count      = count_q;
   assign step_pulse = step_pulse_q;
   assign dir        = dir_q;
   assign seg        = seg_q;

endmodule
